gumnut_ctrl_unit: RTL
=====================

Name: gumnut_ctrl_unit

Overview:
- Control and sequencing stage directly upstream of the Gumnut datapath unit.
- Owns the 12-bit PC, instruction fetch handshake, data/port bus handshakes, return stack and interrupt state.
- Consumes the datapath's decoded fields (op_e, func_e, addr_e, disp_e, offset_e, rs_o) and flags (carry_e, zero_e).
- Produces every datapath control strobe (RegWrt_c, ClkEn_e, RegMux_c, op2_c, ALUOp_c).

Parameters:
- STACK_DEPTH, 8, return-stack entries (power of two, 2..16).
- INT_VECTOR, 12'h001, PC loaded on interrupt entry.

Ports:
- clk_i in 1: clock, rising edge.
- rst_i in 1: asynchronous reset, active-low (asserted when 0).
- op_e in 7: one-hot class. Bit0 ALU-reg, bit1 ALU-immed, bit2 shift, bit3 memory, bit4 branch, bit5 jump, bit6 misc.
- func_e in 3: sub-function within class.
- addr_e in 12: jump target.
- disp_e in 8: signed branch displacement.
- offset_e in 8: memory offset.
- rs_o in 8: base register value from datapath.
- carry_e in 1: registered carry flag.
- zero_e in 1: registered zero flag.
- inst_adr_o out 12: fetch address (=PC).
- inst_cyc_o out 1: fetch bus cycle.
- inst_stb_o out 1: fetch bus strobe.
- inst_ack_i in 1: fetch acknowledge; also the datapath IR load enable.
- data_adr_o out 8: data/port address = rs_o + offset_e, mod 256.
- data_cyc_o out 1: data bus cycle.
- data_stb_o out 1: data bus strobe.
- data_we_o out 1: data write enable.
- data_ack_i in 1: data acknowledge.
- port_cyc_o out 1: port bus cycle.
- port_stb_o out 1: port bus strobe.
- port_we_o out 1: port write enable.
- port_ack_i in 1: port acknowledge.
- int_req_i in 1: level interrupt request.
- int_ack_o out 1: one-cycle interrupt acknowledge.
- RegWrt_c out 1: register-file write.
- ClkEn_e out 1: register-file/flag clock enable.
- RegMux_c out 2: write-back select; 00 ALU, 01 data, 10 port.
- op2_c out 1: ALU operand select; 1 rs2, 0 immediate.
- ALUOp_c out 4: ALU operation select.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WRITE_BACK, INT, WAIT.
- Reset (rst_i=0, async):
  - state=FETCH, PC=0, stack pointer=0, int_en=0, int_pc=0.
  - All cyc/stb/we, RegWrt_c, ClkEn_e, int_ack_o = 0; RegMux_c=00, op2_c=0, ALUOp_c=0.
  - Reset mid-bus-cycle drops cyc/stb immediately.
- FETCH:
  - cyc/stb high, inst_adr_o=PC; hold until inst_ack_i, then DECODE.
  - If int_en & int_req_i on FETCH entry, go to INT instead of starting a fetch.
- DECODE: one cycle (register read), then EXECUTE.
- EXECUTE, ALU-reg/ALU-immed:
  - ALUOp_c={0,func_e}; op2_c=1 for reg, 0 for immed.
  - ClkEn_e=RegWrt_c=1, RegMux_c=00; PC+1; then FETCH.
- EXECUTE, shift: ALUOp_c={2'b10,func_e[1:0]}, op2_c=0; write as ALU; PC+1; then FETCH.
- EXECUTE, memory (func 0 ldm, 1 stm, 2 inp, 3 out): latch data_adr_o, then MEM.
- MEM:
  - ldm/stm drive the data bus; inp/out drive the port bus. we=1 for stm/out.
  - Hold until the matching ack; PC+1.
  - ldm/inp then WRITE_BACK; stm/out then FETCH.
  - A non-matching ack is ignored.
- WRITE_BACK: one cycle; ClkEn_e=RegWrt_c=1, RegMux_c=01 (ldm) or 10 (inp); then FETCH.
- Branch (func 0 bz, 1 bnz, 2 bc, 3 bnc; 4-7 never taken):
  - Taken: PC = PC+1+sign-extend(disp_e), mod 4096.
  - Not taken: PC+1.
  - No register write; then FETCH.
- Jump:
  - func 0 jmp: PC=addr_e.
  - func 1 jsb: push PC+1, PC=addr_e.
  - Stack is circular; pointer wraps mod STACK_DEPTH, so overflow overwrites the oldest entry.
- Misc:
  - func 0 ret: pop to PC; underflow wraps and returns that slot.
  - func 1 reti: PC=int_pc, int_en=1.
  - func 2 enai: int_en=1.
  - func 3 disi: int_en=0.
  - func 4 wait / 5 stby: PC+1, enter WAIT.
  - func 6/7: nop. Non-PC-writing misc ops advance PC+1.
- INT:
  - One cycle: int_pc=PC, int_en=0, PC=INT_VECTOR, int_ack_o=1; then FETCH.
- WAIT:
  - Outputs idle; leave to INT when int_en & int_req_i.
  - With int_en=0, WAIT is exited only by reset.
- op_e with zero or multiple bits set: nop, PC+1.
- ClkEn_e is 0 in every state not listed above as asserting it; flags change only then.

Optional Feature:
- GUMNUT_INT_EN defined: interrupt logic as specified.
- Undefined:
  - INT state, int_en and int_pc removed; int_ack_o tied 0; int_req_i ignored.
  - reti/enai/disi execute as nop (PC+1).
  - wait/stby execute as nop and never enter WAIT.

Test Plan:
- Reset, then ALU-reg add (op_e=0000001, func_e=0) with ack on the 2nd fetch cycle -> EXECUTE shows ALUOp_c=0000, op2_c=1, RegWrt_c=ClkEn_e=1 for exactly 1 cycle; next inst_adr_o=001.
- ldm with rs_o=8'hF0, offset_e=8'h20, data_ack after 3 cycles -> data_adr_o=8'h10; data_stb held 3 cycles, we=0; WRITE_BACK RegMux_c=01; PC+1.
- bz at PC=12'h005, disp_e=8'hFB, zero_e=1 -> next PC=12'h001; with zero_e=0 -> PC=12'h006.
- jsb to 12'h100 from PC=12'h010 nine times with STACK_DEPTH=8, then ret ×8 -> jsb leaves PC=12'h100; each ret returns to 12'h101.
- enai, then int_req_i=1 at PC=12'h020 -> one-cycle int_ack_o, PC=12'h001; reti restores PC=12'h020, int_en=1.
- rst_i low mid port out (port_stb high) -> stb/cyc drop same cycle; PC=0, state FETCH after release.

Source files
------------

// File: rtl/gumnut_ctrl_unit.sv
// rtl/gumnut_ctrl_unit.sv - Gumnut control/sequencing FSM; interrupts enabled by GUMNUT_INT_EN
// PC, fetch/data/port handshakes, circular return stack and datapath strobes.
module gumnut_ctrl_unit #(
    parameter int          STACK_DEPTH = 8,
    parameter logic [11:0] INT_VECTOR  = 12'h001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  op_e,
    input  logic [2:0]  func_e,
    input  logic [11:0] addr_e,
    input  logic [7:0]  disp_e,
    input  logic [7:0]  offset_e,
    input  logic [7:0]  rs_o,
    input  logic        carry_e,
    input  logic        zero_e,
    output logic [11:0] inst_adr_o,
    output logic        inst_cyc_o,
    output logic        inst_stb_o,
    input  logic        inst_ack_i,
    output logic [7:0]  data_adr_o,
    output logic        data_cyc_o,
    output logic        data_stb_o,
    output logic        data_we_o,
    input  logic        data_ack_i,
    output logic        port_cyc_o,
    output logic        port_stb_o,
    output logic        port_we_o,
    input  logic        port_ack_i,
    input  logic        int_req_i,
    output logic        int_ack_o,
    output logic        RegWrt_c,
    output logic        ClkEn_e,
    output logic [1:0]  RegMux_c,
    output logic        op2_c,
    output logic [3:0]  ALUOp_c
);
    localparam int SPW = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITE_BACK, INT, WAIT} state_t;

    state_t         state;
    logic [11:0]    pc;
    logic [SPW-1:0] sp;
    logic [11:0]    stack [STACK_DEPTH];
    logic [1:0]     mem_func;
    logic [11:0]    pc_next;
    logic [11:0]    br_target;
    logic           taken;
    logic           int_pending;

`ifdef GUMNUT_INT_EN
    logic           int_en;
    logic [11:0]    int_pc;
    assign int_pending = int_en & int_req_i;
`else
    logic           unused_int_req;
    assign unused_int_req = int_req_i;
    assign int_pending    = 1'b0;
`endif

    assign inst_adr_o = pc;
    assign pc_next    = pc + 12'd1;
    assign br_target  = pc_next + {{4{disp_e[7]}}, disp_e};

    always_comb begin
        taken = 1'b0;
        case (func_e)
            3'd0:    taken = zero_e;
            3'd1:    taken = ~zero_e;
            3'd2:    taken = carry_e;
            3'd3:    taken = ~carry_e;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= FETCH;
            pc         <= '0;
            sp         <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
            mem_func   <= '0;
            inst_cyc_o <= 1'b0;
            inst_stb_o <= 1'b0;
            data_adr_o <= '0;
            data_cyc_o <= 1'b0;
            data_stb_o <= 1'b0;
            data_we_o  <= 1'b0;
            port_cyc_o <= 1'b0;
            port_stb_o <= 1'b0;
            port_we_o  <= 1'b0;
            int_ack_o  <= 1'b0;
            RegWrt_c   <= 1'b0;
            ClkEn_e    <= 1'b0;
            RegMux_c   <= 2'b00;
            op2_c      <= 1'b0;
            ALUOp_c    <= '0;
`ifdef GUMNUT_INT_EN
            int_en     <= 1'b0;
            int_pc     <= '0;
`endif
        end else begin
            int_ack_o <= 1'b0;
            case (state)
                FETCH: begin
                    // First FETCH cycle is the interrupt decision point; the bus starts the cycle after.
                    if (!inst_cyc_o) begin
                        if (int_pending) begin
                            state     <= INT;
                            int_ack_o <= 1'b1;
                        end else begin
                            inst_cyc_o <= 1'b1;
                            inst_stb_o <= 1'b1;
                        end
                    end else if (inst_ack_i) begin
                        inst_cyc_o <= 1'b0;
                        inst_stb_o <= 1'b0;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    state <= EXECUTE;
                    case (op_e)
                        7'b0000001, 7'b0000010: begin
                            ALUOp_c  <= {1'b0, func_e};
                            op2_c    <= op_e[0];
                            RegWrt_c <= 1'b1;
                            ClkEn_e  <= 1'b1;
                            RegMux_c <= 2'b00;
                        end
                        7'b0000100: begin
                            ALUOp_c  <= {2'b10, func_e[1:0]};
                            op2_c    <= 1'b0;
                            RegWrt_c <= 1'b1;
                            ClkEn_e  <= 1'b1;
                            RegMux_c <= 2'b00;
                        end
                        default: ;
                    endcase
                end
                EXECUTE: begin
                    RegWrt_c <= 1'b0;
                    ClkEn_e  <= 1'b0;
                    ALUOp_c  <= '0;
                    op2_c    <= 1'b0;
                    state    <= FETCH;
                    case (op_e)
                        7'b0001000: begin
                            if (!func_e[2]) begin
                                data_adr_o <= rs_o + offset_e;
                                mem_func   <= func_e[1:0];
                                data_cyc_o <= ~func_e[1];
                                data_stb_o <= ~func_e[1];
                                data_we_o  <= ~func_e[1] & func_e[0];
                                port_cyc_o <= func_e[1];
                                port_stb_o <= func_e[1];
                                port_we_o  <= func_e[1] & func_e[0];
                                state      <= MEM;
                            end else begin
                                pc <= pc_next;
                            end
                        end
                        7'b0010000: pc <= taken ? br_target : pc_next;
                        7'b0100000: begin
                            case (func_e)
                                3'd0: pc <= addr_e;
                                3'd1: begin
                                    stack[sp] <= pc_next;
                                    sp        <= sp + 1'b1;
                                    pc        <= addr_e;
                                end
                                default: pc <= pc_next;
                            endcase
                        end
                        7'b1000000: begin
                            case (func_e)
                                3'd0: begin
                                    sp <= sp - 1'b1;
                                    pc <= stack[sp - 1'b1];
                                end
`ifdef GUMNUT_INT_EN
                                3'd1: begin
                                    pc     <= int_pc;
                                    int_en <= 1'b1;
                                end
                                3'd2: begin
                                    int_en <= 1'b1;
                                    pc     <= pc_next;
                                end
                                3'd3: begin
                                    int_en <= 1'b0;
                                    pc     <= pc_next;
                                end
                                3'd4, 3'd5: begin
                                    pc    <= pc_next;
                                    state <= WAIT;
                                end
`endif
                                default: pc <= pc_next;
                            endcase
                        end
                        default: pc <= pc_next;
                    endcase
                end
                MEM: begin
                    // Only the ack of the bus actually in use completes the access.
                    if ((data_cyc_o && data_ack_i) || (port_cyc_o && port_ack_i)) begin
                        data_cyc_o <= 1'b0;
                        data_stb_o <= 1'b0;
                        data_we_o  <= 1'b0;
                        port_cyc_o <= 1'b0;
                        port_stb_o <= 1'b0;
                        port_we_o  <= 1'b0;
                        pc         <= pc_next;
                        if (!mem_func[0]) begin
                            state    <= WRITE_BACK;
                            RegWrt_c <= 1'b1;
                            ClkEn_e  <= 1'b1;
                            RegMux_c <= mem_func[1] ? 2'b10 : 2'b01;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                WRITE_BACK: begin
                    RegWrt_c <= 1'b0;
                    ClkEn_e  <= 1'b0;
                    RegMux_c <= 2'b00;
                    state    <= FETCH;
                end
                INT: begin
`ifdef GUMNUT_INT_EN
                    int_pc <= pc;
                    int_en <= 1'b0;
                    pc     <= INT_VECTOR;
`endif
                    state  <= FETCH;
                end
                WAIT: begin
                    if (int_pending) begin
                        state     <= INT;
                        int_ack_o <= 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule
